instruction_fetch_unit: RTL

Instruction fetch stage of the RISC-V core. It sits directly upstream of the control unit and datapath. It owns the program counter and fetches one 32-bit instruction at a time from instruction memory over a request/grant/response handshake. It presents the instruction with a valid/ready handshake and updates the PC to PC+4 or to the resolved branch target when the consumer accepts the instruction.

---
 rtl/instruction_fetch_unit_if.sv | 30 +++
 rtl/instruction_fetch_unit.sv | 82 ++++++++
 2 files changed

// File: rtl/instruction_fetch_unit_if.sv
// Fetch stage bus: instruction memory request/grant/response plus
// the valid/ready instruction hand-off towards decode.
interface instruction_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] Instruction;
    logic [31:0] PC;
    logic        Instr_Valid;
    logic        Instr_Ready;
    logic        Branch_Taken;
    logic [31:0] Branch_Target;
    logic        Misaligned;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        output Instruction, PC, Instr_Valid, Misaligned,
        input  Instr_Ready, Branch_Taken, Branch_Target
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        input  Instruction, PC, Instr_Valid, Misaligned,
        output Instr_Ready, Branch_Taken, Branch_Target
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word at a time
// and hands it downstream over a valid/ready handshake.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic clk,
    input  logic reset,
    instruction_fetch_unit_if.master bus
);
    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic        mis_q;
    logic        accept;
    logic        capture;
    logic        req;
    logic        valid;

    assign accept  = (state == HOLD) && bus.Instr_Ready;
    assign capture = (state == WAIT) && bus.imem_rvalid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req       = 1'b0;
        valid     = 1'b0;
        unique case (state)
            IDLE: state_nxt = REQ;
            REQ: begin
                req = 1'b1;
                if (bus.imem_gnt) state_nxt = WAIT;
            end
            WAIT: begin
                if (bus.imem_rvalid) state_nxt = HOLD;
            end
            HOLD: begin
                valid = 1'b1;
                if (bus.Instr_Ready) state_nxt = REQ;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Taken targets are forced word-aligned; a dropped low bit is flagged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q  <= RESET_PC;
            mis_q <= 1'b0;
        end else if (accept) begin
            if (bus.Branch_Taken) begin
                pc_q <= {bus.Branch_Target[31:2], 2'b00};
                if (|bus.Branch_Target[1:0]) mis_q <= 1'b1;
            end else begin
                pc_q <= pc_q + 32'd4;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)        instr_q <= 32'h0000_0013;
        else if (capture) instr_q <= bus.imem_rdata;
    end

    assign bus.imem_req    = req;
    assign bus.imem_addr   = pc_q;
    assign bus.Instruction = instr_q;
    assign bus.PC          = pc_q;
    assign bus.Instr_Valid = valid;
    assign bus.Misaligned  = mis_q;
endmodule
